// File: rtl/alu_pkg.sv
// Shared constants for the KGP-RISC execute-stage ALU: opcodes, control/flag bit indices
// and the shifter mode type. Shifter presence is controlled by the ALU_SHIFT_EN macro.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_PASSB = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b1111;

  localparam int unsigned NEG_BIT = 4;

  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_S = 0;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter returning the shifted value and the last bit shifted out.
// Only instantiated when ALU_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0]  a_i,
  input  logic [4:0]   shamt_i,
  input  shift_mode_e  mode_i,
  output logic [31:0]  res_o,
  output logic         carry_o
);

  // A 33-bit window keeps the last bit shifted out; shift amount 0 leaves it at 0.
  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    case (mode_i)
      SH_SLL:  {carry_o, res_o} = {1'b0, a_i} << shamt_i;
      SH_SRL:  {res_o, carry_o} = {a_i, 1'b0} >> shamt_i;
      SH_SRA:  {res_o, carry_o} = $signed({a_i, 1'b0}) >>> shamt_i;
      default: begin
        res_o   = '0;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// 32-bit ALU with registered result and {carry, zero, sign} flags.
// Shift operations are built only when ALU_SHIFT_EN is defined.
module alu
  import alu_pkg::*;
(
  input  logic        clka,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ALU_C,
  output logic [31:0] res,
  output logic [2:0]  flags
);

  logic [3:0]  op;
  logic        neg;
  logic [31:0] b_inv;
  logic [31:0] bx;
  logic [32:0] sum;
  logic [31:0] res_d, res_q;
  logic [2:0]  flags_d, flags_q;
  logic        carry_d;
  logic        valid_d;
  logic [31:0] sh_res;
  logic        sh_carry;

  assign op    = ALU_C[3:0];
  assign neg   = ALU_C[NEG_BIT];
  assign b_inv = neg ? ~B : B;
  assign bx    = b_inv + {31'd0, neg};

  // Carry-in is added in the 33-bit domain so SUB with B = 0 reports carry (no borrow).
  assign sum = {1'b0, A} + {1'b0, b_inv} + {32'd0, neg};

`ifdef ALU_SHIFT_EN
  shift_mode_e sh_mode;

  always_comb begin
    sh_mode = SH_SRA;
    if (op == OP_SLL)      sh_mode = SH_SLL;
    else if (op == OP_SRL) sh_mode = SH_SRL;
  end

  alu_shifter u_shifter (
    .a_i     (A),
    .shamt_i (B[4:0]),
    .mode_i  (sh_mode),
    .res_o   (sh_res),
    .carry_o (sh_carry)
  );
`else
  assign sh_res   = '0;
  assign sh_carry = 1'b0;
`endif

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    valid_d = 1'b1;
    case (op)
      OP_ADD:   {carry_d, res_d} = sum;
      OP_AND:   res_d = A & bx;
      OP_XOR:   res_d = A ^ bx;
      OP_PASSB: res_d = bx;
      OP_OR:    res_d = A | bx;
`ifdef ALU_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA: begin
        res_d   = sh_res;
        carry_d = sh_carry;
      end
`endif
      default:  valid_d = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = '0;
    if (valid_d) begin
      flags_d[FLAG_C] = carry_d;
      flags_d[FLAG_Z] = (res_d == '0);
      flags_d[FLAG_S] = res_d[31];
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign res   = res_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops and compares
// one cycle later. Shift expectations follow the ALU_SHIFT_EN build setting.
module tb_alu;

  logic        clka;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ALU_C;
  logic [31:0] res;
  logic [2:0]  flags;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic [2:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  bit   done;

  alu dut (
    .clka  (clka),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .ALU_C (ALU_C),
    .res   (res),
    .flags (flags)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check(input string name, input logic [31:0] r, input logic [2:0] f);
    n_tests++;
    if (res !== r || flags !== f) begin
      n_fail++;
      $display("FAIL %s: got res=%08h flags=%03b, expected res=%08h flags=%03b",
               name, res, flags, r, f);
    end
  endtask

  task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] c, input logic [31:0] r, input logic [2:0] f);
    exp_t e;
    @(negedge clka);
    A = a; B = b; ALU_C = c;
    e.name = name; e.r = r; e.f = f;
    exp_q.push_back(e);
  endtask

  // Monitor: the ALU has no valid signal, so every edge following an issued op presents one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clka);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, e.r, e.f);
      end
    end
  end

  initial begin
    logic [31:0] s_r [5];
    logic [2:0]  s_f [5];
    n_tests = 0; n_fail = 0; done = 1'b0;
`ifdef ALU_SHIFT_EN
    s_r[0] = 32'hAA94AA94; s_f[0] = 3'b101;
    s_r[1] = 32'hFAA94AA9; s_f[1] = 3'b001;
    s_r[2] = 32'h40000000; s_f[2] = 3'b100;
    s_r[3] = 32'h80000000; s_f[3] = 3'b001;
    s_r[4] = 32'h00000002; s_f[4] = 3'b000;
`else
    for (int i = 0; i < 5; i++) begin
      s_r[i] = '0; s_f[i] = '0;
    end
`endif
    rst = 1'b1; A = 32'h1; B = 32'h1; ALU_C = 5'b00000;
    repeat (3) @(posedge clka);
    #1 check("reset_held", 32'h0, 3'b000);

    @(negedge clka);
    rst = 1'b0;
    #1 check("reset_released", 32'h0, 3'b000);
    apply("add_1_1",     32'h1,        32'h1,        5'b00000, 32'h00000002, 3'b000);
    apply("add_carry",   32'hEAA52AA5, 32'hEAA52AA5, 5'b00000, 32'hD54A554A, 3'b101);
    apply("neg_b",       32'h0,        32'h1,        5'b10100, 32'hFFFFFFFF, 3'b001);
    apply("and",         32'hEAED2AA5, 32'hEAA52AA5, 5'b00001, 32'hEAA52AA5, 3'b001);
    apply("xor",         32'hEAED2AA5, 32'hEAA52AA5, 5'b00010, 32'h00480000, 3'b000);
    apply("sll_2",       32'hEAA52AA5, 32'h2,        5'b00011, s_r[0], s_f[0]);
    apply("sra_2",       32'hEAA52AA5, 32'h2,        5'b01111, s_r[1], s_f[1]);
    apply("sub_zero",    32'h5,        32'h5,        5'b10000, 32'h00000000, 3'b110);
    apply("sub_borrow",  32'h3,        32'h5,        5'b10000, 32'hFFFFFFFE, 3'b001);
    apply("or",          32'hF0,       32'h0F,       5'b00101, 32'h000000FF, 3'b000);
    apply("srl_hi_b",    32'h80000001, 32'h21,       5'b00110, s_r[2], s_f[2]);
    apply("sll_shamt0",  32'h80000000, 32'h20,       5'b00011, s_r[3], s_f[3]);
    apply("unused_op",   32'h5,        32'h5,        5'b00111, 32'h00000000, 3'b000);
    apply("sll_neg_ign", 32'h1,        32'h1,        5'b10011, s_r[4], s_f[4]);
    apply("sub_b0",      32'h7,        32'h0,        5'b10000, 32'h00000007, 3'b100);
    apply("passb_zero",  32'h0,        32'h0,        5'b00100, 32'h00000000, 3'b010);
    apply("and_neg",     32'hFFFFFFFF, 32'h1,        5'b10001, 32'hFFFFFFFF, 3'b001);
    apply("add_before_rst", 32'h10,    32'h20,       5'b00000, 32'h00000030, 3'b000);

    // Async reset between edges clears outputs at once and discards the pending op.
    @(negedge clka);
    A = 32'h1234; B = 32'h1; ALU_C = 5'b00000;
    rst = 1'b1;
    #1 check("async_reset", 32'h0, 3'b000);
    @(posedge clka);
    #1 check("reset_discard", 32'h0, 3'b000);
    @(negedge clka);
    rst = 1'b0;
    apply("after_rst",   32'hFFFFFFFF, 32'h1,        5'b00000, 32'h00000000, 3'b110);
    apply("hold_check",  32'h8,        32'h4,        5'b00101, 32'h0000000C, 3'b000);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clka);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
